// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus shared by the instruction encoder
// and whatever feeds it (program loader on one side, imem on the other).
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    output mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, in_last,
    input  mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into 32-bit MIPS words, buffers them in a
// small FIFO and streams them into instruction memory at consecutive addresses.
module instr_encoder #(
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  instr_encoder_if.slave  bus,
  output logic            o_done,
  output logic            o_err_illegal,
  output logic            o_err_wrap,
  output logic [ADDR_W:0] o_words_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  logic [32:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done;
  logic              r_errIllegal;
  logic              r_errWrap;
  logic              r_illegalLast;
  logic [ADDR_W:0]   r_words;

  logic              w_full;
  logic              w_accept;
  logic              w_legal;
  logic              w_push;
  logic              w_pop;
  logic [32:0]       w_head;
  logic [31:0]       w_word;
  logic [PTR_W:0]    w_countNext;

  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_legal     = !bus.in_op[3];
  assign w_push      = w_accept && w_legal && !i_reset;
  assign w_pop       = (r_state == S_WRITE) && bus.mem_ack;
  assign w_head      = r_fifo[r_rdPtr];
  assign w_countNext = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

  assign bus.in_ready  = !w_full && (r_state != S_DONE) && !i_start;
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = bus.mem_we ? w_head[31:0] : 32'h0;

  assign o_done          = r_done;
  assign o_err_illegal   = r_errIllegal;
  assign o_err_wrap      = r_errWrap;
  assign o_words_written = r_words;

  always_comb begin
    w_word = 32'h0;
    case (bus.in_op[2:0])
      3'd0:    w_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd1:    w_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd2:    w_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
      3'd3:    w_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd4:    w_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd5:    w_word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd6:    w_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
      default: w_word = {6'b000011, bus.in_target};
    endcase
  end

  // Storage needs no reset: pointers and the mem_wdata mask hide stale entries.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wrPtr] <= {bus.in_last, w_word};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_start) begin
      r_state       <= S_IDLE;
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_addr        <= BASE_ADDR;
      r_done        <= 1'b0;
      r_errIllegal  <= 1'b0;
      r_errWrap     <= 1'b0;
      r_illegalLast <= 1'b0;
      r_words       <= '0;
    end else begin
      r_count <= w_countNext;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_accept && !w_legal) begin
        r_errIllegal <= 1'b1;
        if (bus.in_last) begin
          r_illegalLast <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
        r_addr  <= r_addr + ADDR_W'(1);
        if (r_addr == {ADDR_W{1'b1}}) begin
          r_errWrap <= 1'b1;
        end
        if (!r_words[ADDR_W]) begin
          r_words <= r_words + (ADDR_W+1)'(1);
        end
      end
      // An illegal request flagged as last still ends the program once drained.
      case (r_state)
        S_IDLE: begin
          if (w_push) begin
            r_state <= S_WRITE;
          end else if (r_illegalLast) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_WRITE: begin
          if (w_pop) begin
            if (w_head[32]) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (w_countNext == '0) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: accepted requests push their expected
// imem writes; a negedge monitor compares every presented write against them.
module tb_instr_encoder;

  localparam int ADDR_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            done;
  logic            errIllegal;
  logic            errWrap;
  logic [ADDR_W:0] wordsWritten;

  int checkCount = 0;
  int passCount  = 0;

  logic [ADDR_W-1:0] expAddrQ [$];
  logic [31:0]       expDataQ [$];
  logic [ADDR_W-1:0] nextAddr;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (4),
    .BASE_ADDR  (8'h00)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_start         (start),
    .bus             (bus),
    .o_done          (done),
    .o_err_illegal   (errIllegal),
    .o_err_wrap      (errWrap),
    .o_words_written (wordsWritten)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Stalled writes must hold the queue head; acked writes retire it.
  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      if (expDataQ.size() == 0) begin
        checkOutput("unexpectedWrite", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        checkOutput("writeAddr", 32'(bus.mem_addr), 32'(expAddrQ[0]));
        checkOutput("writeData", bus.mem_wdata, expDataQ[0]);
        if (bus.mem_ack) begin
          void'(expAddrQ.pop_front());
          void'(expDataQ.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                               input logic [25:0] target, input logic last, input logic [31:0] expWord);
    int waitCycles = 0;
    bus.in_op     = op;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_funct  = funct;
    bus.in_imm    = imm;
    bus.in_target = target;
    bus.in_last   = last;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waitCycles < 50) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checkOutput("acceptTimeout", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!op[3]) begin
      expAddrQ.push_back(nextAddr);
      expDataQ.push_back(expWord);
      nextAddr++;
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitDrained();
    int n = 0;
    while ((expDataQ.size() != 0 || bus.mem_we) && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drained", 32'(expDataQ.size()), 32'h0);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("doneSeen", 32'(done), 32'h1);
  endtask

  task automatic pulseStart();
    start        = 1'b1;
    bus.in_op    = 4'd4;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("readyDuringStart", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    expAddrQ.delete();
    expDataQ.delete();
    nextAddr = '0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    nextAddr      = '0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_rs     = '0;
    bus.in_rt     = '0;
    bus.in_rd     = '0;
    bus.in_funct  = '0;
    bus.in_imm    = '0;
    bus.in_target = '0;
    bus.in_last   = 1'b0;
    bus.mem_ack   = 1'b0;
    waitCycles(2);
    reset = 1'b0;
    waitCycles(5);

    checkOutput("rstReady", 32'(bus.in_ready), 32'h1);
    checkOutput("rstWe", 32'(bus.mem_we), 32'h0);
    checkOutput("rstAddr", 32'(bus.mem_addr), 32'h0);
    checkOutput("rstWdata", bus.mem_wdata, 32'h0);
    checkOutput("rstDone", 32'(done), 32'h0);
    checkOutput("rstErrIllegal", 32'(errIllegal), 32'h0);
    checkOutput("rstErrWrap", 32'(errWrap), 32'h0);
    checkOutput("rstWords", 32'(wordsWritten), 32'h0);

    // Single addi: write must be presented the cycle after acceptance.
    bus.mem_ack = 1'b1;
    applyStimulus(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0, 32'h2022_0005);
    checkOutput("latencyWe", 32'(bus.mem_we), 32'h1);
    waitDrained();
    checkOutput("singleWords", 32'(wordsWritten), 32'h1);

    pulseStart();
    checkOutput("startAddr", 32'(bus.mem_addr), 32'h0);
    checkOutput("startWords", 32'(wordsWritten), 32'h0);
    waitCycles(2);
    checkOutput("noWriteAfterStart", 32'(bus.mem_we), 32'h0);

    // Short program ending in jal marked last.
    applyStimulus(4'd2, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'd0, 1'b0, 32'h0022_1820);
    applyStimulus(4'd0, 5'd29, 5'd8, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b0, 32'h8FA8_0004);
    applyStimulus(4'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'h10, 1'b1, 32'h0C00_0010);
    waitDone();
    checkOutput("progWords", 32'(wordsWritten), 32'h3);
    checkOutput("progReady", 32'(bus.in_ready), 32'h0);
    checkOutput("progWe", 32'(bus.mem_we), 32'h0);
    checkOutput("progQueue", 32'(expDataQ.size()), 32'h0);

    pulseStart();
    checkOutput("startClearsDone", 32'(done), 32'h0);

    // Backpressure: fill the FIFO with the memory stalled.
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'(16'h0100 + i), 26'd0, 1'b0, 32'h2022_0100 + 32'(i));
    end
    checkOutput("fullReady", 32'(bus.in_ready), 32'h0);
    fork
      applyStimulus(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0104, 26'd0, 1'b0, 32'h2022_0104);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("stallReady", 32'(bus.in_ready), 32'h0);
        end
        @(posedge clk);
        #1 bus.mem_ack = 1'b1;
      end
    join
    waitDrained();
    checkOutput("bpWords", 32'(wordsWritten), 32'h5);
    checkOutput("bpAddr", 32'(bus.mem_addr), 32'h5);

    // Illegal op is dropped but flagged; flag stays set across legal traffic.
    applyStimulus(4'hA, 5'd1, 5'd2, 5'd3, 6'd0, 16'h1111, 26'd0, 1'b0, 32'h0);
    waitCycles(3);
    checkOutput("illegalFlag", 32'(errIllegal), 32'h1);
    checkOutput("illegalNoWrite", 32'(bus.mem_we), 32'h0);
    checkOutput("illegalWords", 32'(wordsWritten), 32'h5);
    applyStimulus(4'd5, 5'd3, 5'd4, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0, 32'h3064_00FF);
    applyStimulus(4'd1, 5'd2, 5'd5, 5'd0, 6'd0, 16'hFFFC, 26'd0, 1'b0, 32'hAC45_FFFC);
    applyStimulus(4'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0, 32'h1080_FFFF);
    applyStimulus(4'd6, 5'd0, 5'd9, 5'd31, 6'h3F, 16'h1234, 26'h3FFFFFF, 1'b0, 32'h3409_1234);
    waitDrained();
    checkOutput("illegalSticky", 32'(errIllegal), 32'h1);
    checkOutput("mixWords", 32'(wordsWritten), 32'h9);
    applyStimulus(4'hF, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000, 26'd0, 1'b1, 32'h0);
    waitDone();
    pulseStart();
    checkOutput("startClearsIllegal", 32'(errIllegal), 32'h0);
    checkOutput("startClearsDone2", 32'(done), 32'h0);
    checkOutput("startAddr2", 32'(bus.mem_addr), 32'h0);
    checkOutput("startWords2", 32'(wordsWritten), 32'h0);

    // Wrap: 257 writes cover the whole address space plus one.
    for (int i = 0; i < 257; i++) begin
      applyStimulus(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'(i), 26'd0, 1'b0, 32'h2022_0000 + 32'(i));
    end
    waitDrained();
    checkOutput("wrapFlag", 32'(errWrap), 32'h1);
    checkOutput("wrapWordsSat", 32'(wordsWritten), 32'h100);
    checkOutput("wrapAddr", 32'(bus.mem_addr), 32'h1);

    // Reset in the middle of a stalled write with three entries queued.
    pulseStart();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'(16'h0300 + i), 26'd0, 1'b0, 32'h2022_0300 + 32'(i));
    end
    checkOutput("preResetWe", 32'(bus.mem_we), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    expAddrQ.delete();
    expDataQ.delete();
    nextAddr = '0;
    checkOutput("resetWe", 32'(bus.mem_we), 32'h0);
    checkOutput("resetAddr", 32'(bus.mem_addr), 32'h0);
    checkOutput("resetReady", 32'(bus.in_ready), 32'h1);
    waitCycles(1);
    reset       = 1'b0;
    bus.mem_ack = 1'b1;
    waitCycles(5);
    checkOutput("postResetWe", 32'(bus.mem_we), 32'h0);
    checkOutput("postResetWords", 32'(wordsWritten), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
